// File: rtl/dac_ltc26x4_pkg.sv
// ----------------------------------------------------------------------------
// dac_ltc26x4_pkg
// Shared definitions for the LTC2604/2614/2624 receiver: command codes,
// broadcast address, frame-length constants and the frame FSM states.
// ----------------------------------------------------------------------------
package dac_ltc26x4_pkg;

  localparam logic [3:0] CMD_WR_IN      = 4'h0;
  localparam logic [3:0] CMD_UPD        = 4'h1;
  localparam logic [3:0] CMD_WR_UPD_ALL = 4'h2;
  localparam logic [3:0] CMD_WR_UPD     = 4'h3;
  localparam logic [3:0] CMD_PWR_DN     = 4'h4;
  localparam logic [3:0] CMD_NOP        = 4'hF;

  localparam logic [3:0] ADDR_ALL = 4'hF;

  localparam logic [5:0] LEN_24  = 6'd24;
  localparam logic [5:0] LEN_32  = 6'd32;
  localparam logic [5:0] CNT_MAX = 6'd63;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_DECODE = 2'd2
  } state_e;

  function automatic logic cmd_valid(input logic [3:0] cmd);
    case (cmd)
      CMD_WR_IN, CMD_UPD, CMD_WR_UPD_ALL,
      CMD_WR_UPD, CMD_PWR_DN, CMD_NOP: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dac_ltc26x4_rx_sync.sv
// ----------------------------------------------------------------------------
// spi_in_sync
// Brings one asynchronous SPI-side input into the clk domain through
// SYNC_STAGES flops, then one edge register for single-clk rise/fall strobes.
// RST_VAL is the idle level of the line, so reset release never looks like
// an edge (matters for the active-low CS and CLR lines).
// Ports:
//   clk, rst  system clock, synchronous active-high reset
//   d         asynchronous input
//   q         synchronised level
//   rise/fall 1-clk strobes on synchronised edges
// ----------------------------------------------------------------------------
module spi_in_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    edge_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      edge_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      edge_q <= edge_d;
    end
  end

  assign q    = sync_q[SYNC_STAGES-1];
  assign rise = q & ~edge_q;
  assign fall = ~q & edge_q;

endmodule

// File: rtl/dac_ltc26x4_rx.sv
// ----------------------------------------------------------------------------
// dac_ltc26x4_rx
// Receiver image of an LTC2604/2614/2624 DAC. SPI lines are synchronised to
// clk; 24- or 32-bit frames are decoded into per-channel input and DAC
// registers, with power-down tracking and per-frame error pulses.
// Optional macro DAC_LTC26X4_SDO_EN builds the SDO echo on DAC_OUT
// (otherwise DAC_OUT is tied low).
// Ports:
//   clk, rst        system clock (>= 4x SPI_SCK), sync active-high reset
//   SPI_SCK         SPI clock            DAC_CS   chip select, active low
//   DAC_CLR         clear, active low    SPI_MOSI serial data, MSB first
//   DAC_OUT         SDO echo
//   dac_code        DAC registers, channel n at [n*DATA_W +: DATA_W]
//   dac_pd          per-channel power-down state
//   frame_done      1-clk pulse per decoded/rejected frame
//   err_len/err_addr/err_cmd/err_init  error pulses, valid with frame_done
// ----------------------------------------------------------------------------
module dac_ltc26x4_rx #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       SPI_SCK,
  input  logic                       DAC_CS,
  input  logic                       DAC_CLR,
  input  logic                       SPI_MOSI,
  output logic                       DAC_OUT,
  output logic [CHANNELS*DATA_W-1:0] dac_code,
  output logic [CHANNELS-1:0]        dac_pd,
  output logic                       frame_done,
  output logic                       err_len,
  output logic                       err_addr,
  output logic                       err_cmd,
  output logic                       err_init
);
  import dac_ltc26x4_pkg::*;

  localparam logic [4:0] CH_LIM = 5'(CHANNELS);

  // --------------------------------------------------------------------------
  // Input synchronisers
  // --------------------------------------------------------------------------
  logic sck_s, sck_rise, sck_fall;
  logic cs_s, cs_rise, cs_fall;
  logic clr_s, clr_rise, clr_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst(rst), .d(SPI_SCK), .q(sck_s), .rise(sck_rise), .fall(sck_fall)
  );
  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .d(DAC_CS), .q(cs_s), .rise(cs_rise), .fall(cs_fall)
  );
  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_clr (
    .clk(clk), .rst(rst), .d(DAC_CLR), .q(clr_s), .rise(clr_rise), .fall(clr_fall)
  );
  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(SPI_MOSI), .q(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic                pend_q, pend_d;      // CS fall seen during DECODE
  logic [5:0]          cnt_q, cnt_d;
  logic [31:0]         sr_q, sr_d;
  logic                inited_q, inited_d;
  logic [DATA_W-1:0]   in_q [CHANNELS];
  logic [DATA_W-1:0]   in_d [CHANNELS];
  logic [DATA_W-1:0]   dac_q [CHANNELS];
  logic [DATA_W-1:0]   dac_d [CHANNELS];
  logic [CHANNELS-1:0] pd_q, pd_d;
  logic                done_q, done_d;
  logic                err_len_q, err_len_d;
  logic                err_addr_q, err_addr_d;
  logic                err_cmd_q, err_cmd_d;
  logic                err_init_q, err_init_d;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // FSM: next state. A low CLR overrides any CS edge in the same clk.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    if (!clr_s) begin
      state_d = ST_IDLE;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          pend_d = 1'b0;
          if (cs_fall || pend_q) state_d = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (cs_rise) state_d = ST_DECODE;
        end
        ST_DECODE: begin
          state_d = ST_IDLE;
          if (cs_fall) pend_d = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM: outputs and datapath next values
  logic [3:0]        f_cmd, f_addr;
  logic [DATA_W-1:0] f_code;
  logic              len_ok, addr_ok, cmd_ok, accept, sel;

  always_comb begin
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    in_d       = in_q;
    dac_d      = dac_q;
    pd_d       = pd_q;
    inited_d   = inited_q | clr_rise;
    done_d     = 1'b0;
    err_len_d  = 1'b0;
    err_addr_d = 1'b0;
    err_cmd_d  = 1'b0;
    err_init_d = 1'b0;
    sel        = 1'b0;

    f_cmd   = sr_q[23:20];
    f_addr  = sr_q[19:16];
    f_code  = sr_q[15 -: DATA_W];
    len_ok  = (cnt_q == LEN_24) || (cnt_q == LEN_32);
    addr_ok = (f_addr == ADDR_ALL) || ({1'b0, f_addr} < CH_LIM);
    cmd_ok  = cmd_valid(f_cmd);
    accept  = len_ok && inited_q && addr_ok && cmd_ok;

    if (!clr_s) begin
      for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
        in_d[ch]  = '0;
        dac_d[ch] = '0;
      end
    end else begin
      if (state_q == ST_IDLE && state_d == ST_SHIFT) cnt_d = '0;

      if (state_q == ST_SHIFT && sck_rise && !cs_s) begin
        sr_d  = {sr_q[30:0], mosi_s};
        cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 6'd1;
      end

      if (state_q == ST_DECODE) begin
        done_d     = 1'b1;
        err_len_d  = !len_ok;
        err_addr_d = !addr_ok;
        err_cmd_d  = !cmd_ok;
        err_init_d = !inited_q;
        if (accept) begin
          for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
            sel = (f_addr == ADDR_ALL) || (f_addr == ch[3:0]);
            case (f_cmd)
              CMD_WR_IN: begin
                if (sel) in_d[ch] = f_code;
              end
              CMD_UPD: begin
                if (sel) begin
                  dac_d[ch] = in_q[ch];
                  pd_d[ch]  = 1'b0;
                end
              end
              // Written value bypasses in_q so every channel updates in one clk
              CMD_WR_UPD_ALL: begin
                if (sel) in_d[ch] = f_code;
                dac_d[ch] = sel ? f_code : in_q[ch];
                pd_d[ch]  = 1'b0;
              end
              CMD_WR_UPD: begin
                if (sel) begin
                  in_d[ch]  = f_code;
                  dac_d[ch] = f_code;
                  pd_d[ch]  = 1'b0;
                end
              end
              CMD_PWR_DN: begin
                if (sel) pd_d[ch] = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      sr_q       <= '0;
      inited_q   <= 1'b0;
      pd_q       <= '0;
      done_q     <= 1'b0;
      err_len_q  <= 1'b0;
      err_addr_q <= 1'b0;
      err_cmd_q  <= 1'b0;
      err_init_q <= 1'b0;
      for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
        in_q[ch]  <= '0;
        dac_q[ch] <= '0;
      end
    end else begin
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      inited_q   <= inited_d;
      pd_q       <= pd_d;
      done_q     <= done_d;
      err_len_q  <= err_len_d;
      err_addr_q <= err_addr_d;
      err_cmd_q  <= err_cmd_d;
      err_init_q <= err_init_d;
      in_q       <= in_d;
      dac_q      <= dac_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    dac_code = '0;
    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
      dac_code[ch*DATA_W +: DATA_W] = dac_q[ch];
    end
  end

  assign dac_pd     = pd_q;
  assign frame_done = done_q;
  assign err_len    = err_len_q;
  assign err_addr   = err_addr_q;
  assign err_cmd    = err_cmd_q;
  assign err_init   = err_init_q;

`ifdef DAC_LTC26X4_SDO_EN
  // SDO is also loaded on the CS fall so the first bit is presented before
  // the first SCK rise; afterwards it follows sr_q[31] on each SCK fall,
  // replaying the previous frame on a 32-bit transfer.
  logic sdo_q, sdo_d;

  always_comb begin
    sdo_d = sdo_q;
    if (cs_fall || (sck_fall && !cs_s)) sdo_d = sr_q[31];
  end

  always_ff @(posedge clk) begin
    if (rst) sdo_q <= 1'b0;
    else     sdo_q <= sdo_d;
  end

  assign DAC_OUT = sdo_q & ~cs_s;

  logic unused_sync;
  assign unused_sync = ^{sck_s, clr_fall, mosi_rise, mosi_fall};
`else
  assign DAC_OUT = 1'b0;

  logic unused_sync;
  assign unused_sync = ^{sck_s, sck_fall, clr_fall, mosi_rise, mosi_fall, sr_q[31]};
`endif

endmodule

// File: tb/tb_dac_ltc26x4_rx.sv
// ----------------------------------------------------------------------------
// tb_dac_ltc26x4_rx
// Self-checking bench for dac_ltc26x4_rx: directed and randomised SPI frames
// checked against a behavioural channel model. Honours DAC_LTC26X4_SDO_EN.
// ----------------------------------------------------------------------------
module tb_dac_ltc26x4_rx;

  localparam int unsigned CH = 4;
  localparam int unsigned DW = 12;
  localparam int unsigned NS = 2;

  logic clk = 1'b0;
  logic rst, sck, cs, clr, mosi, dac_out;
  logic [CH*DW-1:0] dac_code;
  logic [CH-1:0]    dac_pd;
  logic frame_done, err_len, err_addr, err_cmd, err_init;

  int n_total = 0;
  int n_bad = 0;
  int done_cnt = 0;
  bit sdo_seen = 1'b0;

  logic [DW-1:0] m_in [CH];
  logic [DW-1:0] m_dac [CH];
  logic [CH-1:0] m_pd;
  bit            m_inited;
  logic [63:0]   sdo_cap;
  logic [63:0]   last_bits;

  dac_ltc26x4_rx #(.CHANNELS(CH), .DATA_W(DW), .SYNC_STAGES(NS)) dut (
    .clk(clk), .rst(rst), .SPI_SCK(sck), .DAC_CS(cs), .DAC_CLR(clr),
    .SPI_MOSI(mosi), .DAC_OUT(dac_out), .dac_code(dac_code), .dac_pd(dac_pd),
    .frame_done(frame_done), .err_len(err_len), .err_addr(err_addr),
    .err_cmd(err_cmd), .err_init(err_init)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (dac_out) sdo_seen = 1'b1;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic void model_clear();
    for (int i = 0; i < CH; i++) begin
      m_in[i]  = '0;
      m_dac[i] = '0;
    end
  endfunction

  function automatic logic [63:0] exp_code();
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < CH; i++) r[i*DW +: DW] = m_dac[i];
    return r;
  endfunction

  // Returns {len, addr, cmd, init} error bits and applies an accepted frame.
  function automatic logic [3:0] model_frame(input int nbits, input logic [3:0] cmd,
                                             input logic [3:0] addr, input logic [DW-1:0] code);
    bit len_ok, addr_ok, cmd_ok, hit;
    len_ok  = (nbits == 24) || (nbits == 32);
    addr_ok = (addr == 4'hF) || (int'(addr) < CH);
    cmd_ok  = (cmd <= 4'd4) || (cmd == 4'hF);
    if (len_ok && addr_ok && cmd_ok && m_inited) begin
      for (int i = 0; i < CH; i++) begin
        hit = (addr == 4'hF) || (int'(addr) == i);
        if (hit && (cmd == 4'd0 || cmd == 4'd2 || cmd == 4'd3)) m_in[i] = code;
        if (hit && cmd == 4'd1) begin m_dac[i] = m_in[i]; m_pd[i] = 1'b0; end
        if (hit && cmd == 4'd3) begin m_dac[i] = code; m_pd[i] = 1'b0; end
        if (hit && cmd == 4'd4) m_pd[i] = 1'b1;
      end
      if (cmd == 4'd2) begin
        for (int i = 0; i < CH; i++) m_dac[i] = m_in[i];
        m_pd = '0;
      end
    end
    return {!len_ok, !addr_ok, !cmd_ok, !m_inited};
  endfunction

  // ---------------- stimulus ----------------
  task automatic send_bits(input logic [63:0] v, input int n);
    tick(); cs = 1'b0;
    repeat (6) tick();
    for (int i = n - 1; i >= 0; i--) begin
      mosi = v[i];
      repeat (4) tick();
      sdo_cap[i] = dac_out;
      sck = 1'b1;
      repeat (4) tick();
      sck = 1'b0;
    end
    repeat (4) tick();
  endtask

  task automatic do_frame(input int nbits, input logic [3:0] cmd, input logic [3:0] addr,
                          input logic [15:0] code, input string tag);
    logic [63:0] v;
    logic [23:0] w;
    logic [3:0]  exp_err;
    int          k;
    bit          seen;
    w[23:20]     = cmd;
    w[19:16]     = addr;
    w[15:0]      = 16'($urandom);
    w[15 -: DW]  = code[DW-1:0];
    v            = {$urandom, $urandom};
    v[23:0]      = w;
    last_bits    = v;
    exp_err      = model_frame(nbits, cmd, addr, code[DW-1:0]);
    send_bits(v, nbits);
    cs = 1'b1;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 30) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    chk({tag, "/done"}, 64'(seen), 64'd1);
    if (seen) begin
      chk({tag, "/latency"}, 64'(k), 64'(NS + 2));
      chk({tag, "/err"}, 64'({err_len, err_addr, err_cmd, err_init}), 64'(exp_err));
    end
    @(negedge clk);
    chk({tag, "/pulse"}, 64'(frame_done), 64'd0);
    chk({tag, "/code"}, 64'(dac_code), exp_code());
    chk({tag, "/pd"}, 64'(dac_pd), 64'(m_pd));
  endtask

  task automatic clr_pulse();
    tick(); clr = 1'b0;
    repeat (6) tick();
    clr = 1'b1;
    repeat (6) tick();
    model_clear();
    m_inited = 1'b1;
  endtask

  initial begin
    int d0;
    logic [3:0] c, a;
    int n;
    rst = 1'b1; cs = 1'b1; clr = 1'b1; sck = 1'b0; mosi = 1'b0;
    model_clear(); m_pd = '0; m_inited = 1'b0;
    repeat (5) tick();
    rst = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst/code", 64'(dac_code), 64'd0);
    chk("rst/pd", 64'(dac_pd), 64'd0);
    chk("rst/flags", 64'({frame_done, err_len, err_addr, err_cmd, err_init}), 64'd0);

    do_frame(32, 4'h3, 4'h0, 16'h0555, "noinit");
    clr_pulse();
    do_frame(32, 4'h3, 4'h2, 16'h0ABC, "wrupd_ch2");
    do_frame(32, 4'h0, 4'h1, 16'h0123, "wr_in1");
    do_frame(24, 4'h0, 4'h0, 16'h0456, "wr_in0");
    do_frame(32, 4'h1, 4'hF, 16'h0000, "upd_all");
    do_frame(32, 4'h4, 4'h3, 16'h0000, "pd3");
    do_frame(24, 4'h3, 4'h3, 16'h07FF, "wrupd24_ch3");
    do_frame(31, 4'h3, 4'h1, 16'h0FFF, "len31");
    do_frame(40, 4'h3, 4'h1, 16'h0FFF, "len40");
    do_frame(32, 4'h3, 4'h5, 16'h0111, "addr5");
    do_frame(32, 4'h7, 4'h0, 16'h0222, "cmd7");
    do_frame(24, 4'h2, 4'h1, 16'h0333, "wrupdall");
    do_frame(32, 4'hF, 4'h2, 16'h0444, "nop");

    for (int t = 0; t < 30; t++) begin
      case ($urandom_range(0, 9))
        0: c = 4'h0;
        1: c = 4'h1;
        2: c = 4'h2;
        3: c = 4'h3;
        4: c = 4'h4;
        5: c = 4'hF;
        6: c = 4'($urandom_range(5, 14));
        default: c = 4'($urandom_range(0, 3));
      endcase
      a = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, CH - 1));
      if ($urandom_range(0, 7) == 0) n = ($urandom_range(0, 1) == 1) ? 28 : 36;
      else                           n = ($urandom_range(0, 1) == 1) ? 32 : 24;
      do_frame(n, c, a, 16'($urandom), "rnd");
    end

    // CLR mid-frame: aborts, clears codes, keeps power-down state
    do_frame(32, 4'h4, 4'h1, 16'h0000, "pd1");
    d0 = done_cnt;
    tick(); cs = 1'b0;
    repeat (6) tick();
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin
        clr = 1'b0;
        repeat (6) tick();
        clr = 1'b1;
      end
      mosi = 1'($urandom);
      repeat (4) tick(); sck = 1'b1;
      repeat (4) tick(); sck = 1'b0;
    end
    repeat (4) tick(); cs = 1'b1;
    repeat (20) tick();
    model_clear();
    @(negedge clk);
    chk("clrabort/done", 64'(done_cnt - d0), 64'd0);
    chk("clrabort/code", 64'(dac_code), exp_code());
    chk("clrabort/pd", 64'(dac_pd), 64'(m_pd));
    do_frame(32, 4'h3, 4'h0, 16'h0987, "after_clr");

    // rst mid-frame: discarded, no pulses, all state back to reset
    d0 = done_cnt;
    tick(); cs = 1'b0;
    repeat (6) tick();
    for (int i = 0; i < 12; i++) begin
      mosi = 1'($urandom);
      repeat (4) tick(); sck = 1'b1;
      repeat (4) tick(); sck = 1'b0;
    end
    rst = 1'b1;
    repeat (4) tick(); cs = 1'b1;
    repeat (6) tick(); rst = 1'b0;
    repeat (20) tick();
    model_clear(); m_pd = '0; m_inited = 1'b0;
    @(negedge clk);
    chk("rstmid/done", 64'(done_cnt - d0), 64'd0);
    chk("rstmid/code", 64'(dac_code), 64'd0);
    chk("rstmid/pd", 64'(dac_pd), 64'd0);
    do_frame(24, 4'h3, 4'h1, 16'h0321, "rst_noinit");
    clr_pulse();
    do_frame(24, 4'h3, 4'h1, 16'h0321, "rst_reinit");

`ifdef DAC_LTC26X4_SDO_EN
    begin
      logic [63:0] first;
      do_frame(32, 4'h0, 4'h2, 16'($urandom), "sdo_f1");
      first = last_bits;
      do_frame(32, 4'h0, 4'h3, 16'($urandom), "sdo_f2");
      chk("sdo/echo", 64'(sdo_cap[31:0]), 64'(first[31:0]));
    end
`else
    chk("sdo/tied", 64'(sdo_seen), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
